seven_seg_decoder: RTL and testbench
====================================

Name: seven_seg_decoder

Overview:
- Registered hexadecimal-to-7-segment display decoder.
- Converts a 4-bit nibble (0x0–0xF) into the seven segment drive lines a–g for one digit of a display driver.
- Sits between digit-select/multiplex logic and the display pins.
- Output is registered so the segment lines are glitch-free.

Parameters:
- ACTIVE_LOW, default 0. 0 = segment lit when its bit is 1 (common cathode); 1 = every output bit inverted (common anode).
- RESET_BLANK, default 1. 1 = reset drives all segments unlit; 0 = reset drives the glyph for 0.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst_n  input  1  asynchronous active-low reset.
- in  input  4  hexadecimal digit to display, 0x0–0xF.
- out  output  7  segment drive, bit0=a, bit1=b, bit2=c, bit3=d, bit4=e, bit5=f, bit6=g.

Behaviour:
- Clocking and reset: one clock, clk; reset is asynchronous and active-low, rst_n.
- Reset value: while rst_n=0, out is forced immediately, without waiting for clk.
  - RESET_BLANK=1: out = 7'h00 when ACTIVE_LOW=0, 7'h7F when ACTIVE_LOW=1.
  - RESET_BLANK=0: out = the glyph for 0 (7'h3F, or 7'h40 when inverted).
- Reset release: first decode is captured on the first rising clk edge with rst_n=1.
- Latency: exactly 1 cycle. out after rising edge N is the glyph of in sampled at edge N. No handshake; a new digit is accepted every cycle.
- Glyph table for ACTIVE_LOW=0, as bits g..a in hex:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07
  - 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71
- ACTIVE_LOW=1: out = bitwise NOT of the table entry. Inversion happens before the register, so the output stays glitch-free.
- Full 4-bit coverage: all 16 codes are defined and there are no don't-cares.
- Unknown input: any X/Z bit in in yields the blank pattern, never X propagation in simulation.
- Hold: out holds its value while in is stable, and changes only on clk edges or on reset assertion.
- Reset mid-operation: asserting rst_n mid-cycle forces the reset value at once. Any in change during reset is ignored.
- No other state; no FSM.

Decomposition:
- Package seven_seg_pkg:
  - typedef seg7_t (7-bit logic);
  - localparam constants SEG_0..SEG_F and SEG_BLANK;
  - function hex_to_seg(nibble) returning seg7_t.
- Sub-module seven_seg_lut: purely combinational; in[3:0] -> raw active-high seg7_t.
- Top seven_seg_decoder: instantiates the LUT, applies the ACTIVE_LOW inversion, and owns the async-reset output register.

Test Plan:
- Reset: hold rst_n=0 with in=4'h8 -> out=7'h00 immediately, with no clk edge; release and clock once -> out=7'h7F.
- Sweep: after reset, drive in=0x0..0xF, one value per clock -> out follows the table one cycle later (3F,06,5B,4F,66,6D,7D,07,7F,6F,77,7C,39,5E,79,71).
- Polarity: ACTIVE_LOW=1, in=4'h1 -> out=7'h79; in=4'h8 -> out=7'h00; during reset -> out=7'h7F.
- Reset mid-operation: in=4'hA, out=7'h77; assert rst_n between clock edges -> out=7'h00 without a clock; deassert, clock once with in=4'h3 -> out=7'h4F.
- Latency and hold: change in=4'h2->4'hE just after an edge -> out stays 7'h5B until the next edge, then 7'h79; hold in for 5 cycles -> out constant.
- X handling: drive in=4'bx1x0 for one cycle -> out=7'h00 (blank).

Source files
------------

// File: rtl/seven_seg_pkg.sv
// Seven-segment glyph definitions shared by the decoder.
// Bit order is g..a, active-high (segment lit = 1).
package seven_seg_pkg;

  typedef logic [6:0] seg7_t;

  localparam seg7_t SEG_0     = 7'h3F;
  localparam seg7_t SEG_1     = 7'h06;
  localparam seg7_t SEG_2     = 7'h5B;
  localparam seg7_t SEG_3     = 7'h4F;
  localparam seg7_t SEG_4     = 7'h66;
  localparam seg7_t SEG_5     = 7'h6D;
  localparam seg7_t SEG_6     = 7'h7D;
  localparam seg7_t SEG_7     = 7'h07;
  localparam seg7_t SEG_8     = 7'h7F;
  localparam seg7_t SEG_9     = 7'h6F;
  localparam seg7_t SEG_A     = 7'h77;
  localparam seg7_t SEG_B     = 7'h7C;
  localparam seg7_t SEG_C     = 7'h39;
  localparam seg7_t SEG_D     = 7'h5E;
  localparam seg7_t SEG_E     = 7'h79;
  localparam seg7_t SEG_F     = 7'h71;
  localparam seg7_t SEG_BLANK = 7'h00;

  // Any nibble with X/Z bits falls to the default and shows blank.
  function automatic seg7_t hex_to_seg(input logic [3:0] nibble);
    seg7_t s;
    case (nibble)
      4'h0:    s = SEG_0;
      4'h1:    s = SEG_1;
      4'h2:    s = SEG_2;
      4'h3:    s = SEG_3;
      4'h4:    s = SEG_4;
      4'h5:    s = SEG_5;
      4'h6:    s = SEG_6;
      4'h7:    s = SEG_7;
      4'h8:    s = SEG_8;
      4'h9:    s = SEG_9;
      4'hA:    s = SEG_A;
      4'hB:    s = SEG_B;
      4'hC:    s = SEG_C;
      4'hD:    s = SEG_D;
      4'hE:    s = SEG_E;
      4'hF:    s = SEG_F;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seven_seg_lut.sv
// Combinational hex nibble to active-high segment pattern.
// Unknown input bits resolve to the blank pattern.
module seven_seg_lut
  import seven_seg_pkg::*;
(
  input  logic [3:0] nibble_i,
  output seg7_t      seg_o
);

  // Pure table lookup, no state.
  always_comb begin
    seg_o = hex_to_seg(nibble_i);
  end

endmodule

// File: rtl/seven_seg_decoder.sv
// Registered hex to 7-segment decoder for one display digit.
// Polarity is applied ahead of the register so pins never glitch.
module seven_seg_decoder
  import seven_seg_pkg::*;
#(
  parameter bit ACTIVE_LOW  = 1'b0,
  parameter bit RESET_BLANK = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] in,
  output logic [6:0] out
);

  localparam seg7_t RST_RAW = RESET_BLANK ? SEG_BLANK : SEG_0;
  localparam seg7_t RST_VAL = ACTIVE_LOW ? ~RST_RAW : RST_RAW;

  seg7_t raw;
  seg7_t out_d;
  seg7_t out_q;

  seven_seg_lut u_lut (
    .nibble_i (in),
    .seg_o    (raw)
  );

  // Select drive polarity before the flop.
  always_comb begin
    out_d = ACTIVE_LOW ? ~raw : raw;
  end

  // Output register; reset forces the idle pattern at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) out_q <= RST_VAL;
    else        out_q <= out_d;
  end

  assign out = out_q;

endmodule

// File: tb/tb_seven_seg_decoder.sv
// Self-checking bench for seven_seg_decoder.
// Three instances cover both polarities and both reset glyphs.
module tb_seven_seg_decoder;

  typedef struct {
    logic [3:0] din;
    logic [6:0] exp;
  } vec_t;

  logic       clk;
  logic       rst_n;
  logic [3:0] din;
  logic [3:0] din_b;
  logic [6:0] out_a;
  logic [6:0] out_b;
  logic [6:0] out_c;

  int n_chk;
  int n_fail;

  vec_t vec [16];

  seven_seg_decoder #(
    .ACTIVE_LOW  (1'b0),
    .RESET_BLANK (1'b1)
  ) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .in    (din),
    .out   (out_a)
  );

  seven_seg_decoder #(
    .ACTIVE_LOW  (1'b1),
    .RESET_BLANK (1'b1)
  ) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .in    (din_b),
    .out   (out_b)
  );

  seven_seg_decoder #(
    .ACTIVE_LOW  (1'b0),
    .RESET_BLANK (1'b0)
  ) dut_c (
    .clk   (clk),
    .rst_n (rst_n),
    .in    (din),
    .out   (out_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name,
                       input logic [6:0] act,
                       input logic [6:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t",
               name, act, exp, $time);
    end
  endtask

  initial begin
    logic [6:0] x_exp;
    n_chk  = 0;
    n_fail = 0;

    vec[0]  = '{4'h0, 7'h3F};
    vec[1]  = '{4'h1, 7'h06};
    vec[2]  = '{4'h2, 7'h5B};
    vec[3]  = '{4'h3, 7'h4F};
    vec[4]  = '{4'h4, 7'h66};
    vec[5]  = '{4'h5, 7'h6D};
    vec[6]  = '{4'h6, 7'h7D};
    vec[7]  = '{4'h7, 7'h07};
    vec[8]  = '{4'h8, 7'h7F};
    vec[9]  = '{4'h9, 7'h6F};
    vec[10] = '{4'hA, 7'h77};
    vec[11] = '{4'hB, 7'h7C};
    vec[12] = '{4'hC, 7'h39};
    vec[13] = '{4'hD, 7'h5E};
    vec[14] = '{4'hE, 7'h79};
    vec[15] = '{4'hF, 7'h71};

    // Reset asserted before any clock edge.
    rst_n = 1'b1;
    din   = 4'h8;
    din_b = 4'h8;
    #1 rst_n = 1'b0;
    #2;
    check("rst_async_a", out_a, 7'h00);
    check("rst_async_b", out_b, 7'h7F);
    check("rst_glyph0_c", out_c, 7'h3F);

    // Release and clock once.
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rel_first_a", out_a, 7'h7F);
    check("rel_first_b", out_b, 7'h00);

    // Full sweep, one value per clock.
    for (int i = 0; i < 16; i++) begin
      din   = vec[i].din;
      din_b = vec[i].din;
      @(negedge clk);
      check($sformatf("sweep_a_%0h", vec[i].din), out_a, vec[i].exp);
      check($sformatf("sweep_b_%0h", vec[i].din), out_b, ~vec[i].exp);
    end

    // Polarity spot checks.
    din_b = 4'h1;
    @(negedge clk);
    check("pol_b_1", out_b, 7'h79);
    din_b = 4'h8;
    @(negedge clk);
    check("pol_b_8", out_b, 7'h00);

    // Reset mid-operation.
    din = 4'hA;
    @(negedge clk);
    check("mid_pre_a", out_a, 7'h77);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_a", out_a, 7'h00);
    check("mid_rst_b", out_b, 7'h7F);
    check("mid_rst_c", out_c, 7'h3F);
    din = 4'h5;
    @(posedge clk);
    #1;
    check("mid_ign_a", out_a, 7'h00);
    @(negedge clk);
    rst_n = 1'b1;
    din   = 4'h3;
    @(negedge clk);
    check("mid_rel_a", out_a, 7'h4F);

    // Latency and hold.
    din = 4'h2;
    @(posedge clk);
    #1;
    check("lat_2_a", out_a, 7'h5B);
    din = 4'hE;
    #2;
    check("lat_hold0_a", out_a, 7'h5B);
    @(negedge clk);
    check("lat_hold1_a", out_a, 7'h5B);
    @(posedge clk);
    #1;
    check("lat_e_a", out_a, 7'h79);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("hold_%0d", k), out_a, 7'h79);
    end

    // Unknown input bits show blank; a two-state
    // simulator resolves them to a legal code instead.
    @(negedge clk);
    din = 4'bx1x0;
    @(negedge clk);
    if ($isunknown(din)) x_exp = 7'h00;
    else                 x_exp = vec[din].exp;
    check("xin_a", out_a, x_exp);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
